rf_write_arbiter: RTL and testbench

Arbitrates the register file's single write port between the in-order writeback stage and a long-latency execution unit (mul/div, out-of-band loads). Long-latency results are buffered in a small FIFO and drained into idle writeback slots. A starvation counter guarantees forward progress by stalling writeback when needed. Sits between the WB stage and the register file write port (`regwrite`/`rd`/`writedata`). The register file captures the write on the following falling edge.

---
 rtl/rf_write_arbiter.sv | 116 +++++++++++
 tb/tb_rf_write_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: in-order writeback vs. a buffered long-latency unit,
// with a starvation counter. Optional per-register pending scoreboard: RF_ARB_SCOREBOARD_EN.
module rf_write_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        regwrite,
  output logic [4:0]  rd,
  output logic [31:0] writedata,
  output logic [31:0] busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    starve_q;
  logic          regwrite_q;
  logic [4:0]    rd_q;
  logic [31:0]   writedata_q;

  logic        nonempty, full, force_w, grant_wb, grant_lu, push, pop;
  logic [4:0]  head_rd, sel_rd;
  logic [31:0] sel_data;

  assign nonempty = (cnt_q != '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign head_rd  = fifo_rd_q[head_q];
  // Forcing depends only on FIFO/counter state so wb_stall never loops back through wb_valid.
  assign force_w  = nonempty && (starve_q == 4'(STARVE_MAX));
  assign grant_lu = force_w || (!wb_valid && nonempty);
  assign grant_wb = !force_w && wb_valid;
  assign push     = lu_valid && !full;
  assign pop      = grant_lu;
  assign sel_rd   = grant_lu ? head_rd : wb_rd;
  assign sel_data = grant_lu ? fifo_data_q[head_q] : wb_data;

  assign wb_stall  = force_w;
  assign lu_ready  = !full;
  assign regwrite  = regwrite_q;
  assign rd        = rd_q;
  assign writedata = writedata_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[tail_q]   <= lu_rd;
      fifo_data_q[tail_q] <= lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      regwrite_q  <= 1'b0;
      rd_q        <= '0;
      writedata_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (nonempty && grant_wb)
        starve_q <= (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
      else
        starve_q <= '0;
      // x0 writes are consumed but never reach the register file.
      regwrite_q <= (grant_wb || grant_lu) && (sel_rd != 5'd0);
      if (grant_wb || grant_lu) begin
        rd_q        <= sel_rd;
        writedata_q <= sel_data;
      end
    end
  end

`ifdef RF_ARB_SCOREBOARD_EN
  logic [CW-1:0] pend_q [1:31];
  logic [31:0]   inc_w, dec_w;

  assign inc_w = (push && lu_rd != 5'd0) ? (32'd1 << lu_rd) : 32'd0;
  assign dec_w = (pop && head_rd != 5'd0) ? (32'd1 << head_rd) : 32'd0;

  // Counts rather than flags so duplicate destinations keep busy set until the last pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++) pend_q[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc_w[r] && !dec_w[r])      pend_q[r] <= pend_q[r] + 1'b1;
        else if (dec_w[r] && !inc_w[r]) pend_q[r] <= pend_q[r] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) busy[r] = (pend_q[r] != '0);
  end
`else
  assign busy = '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized + directed bench for rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wb_valid = 1'b0, lu_valid = 1'b0;
  logic [4:0]  wb_rd = '0, lu_rd = '0;
  logic [31:0] wb_data = '0, lu_data = '0;
  logic        wb_stall, lu_ready, regwrite;
  logic [4:0]  rd;
  logic [31:0] writedata, busy;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .regwrite(regwrite), .rd(rd), .writedata(writedata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t        q[$];
  int          losses;
  logic        exp_rw;
  logic [4:0]  exp_rd;
  logic [31:0] exp_wd;
  logic        wb_taken, lu_taken;
  int          nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    losses = 0;
    exp_rw = 1'b0; exp_rd = '0; exp_wd = '0;
    wb_taken = 1'b0; lu_taken = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, advance the model, return just after the edge.
  task automatic cyc();
    logic        ne, frc, rdy, served;
    logic [4:0]  s_rd;
    logic [31:0] s_d, eb;
    ent_t        e;
    @(negedge clk);
    chk("regwrite", 32'(regwrite), 32'(exp_rw));
    if (exp_rw) begin
      chk("rd", 32'(rd), 32'(exp_rd));
      chk("writedata", writedata, exp_wd);
    end
    ne  = q.size() > 0;
    frc = ne && (losses == STARVE_MAX);
    rdy = q.size() < DEPTH;
    eb  = '0;
`ifdef RF_ARB_SCOREBOARD_EN
    foreach (q[i]) if (q[i].rd != 0) eb[q[i].rd] = 1'b1;
`endif
    chk("wb_stall", 32'(wb_stall), 32'(frc));
    chk("lu_ready", 32'(lu_ready), 32'(rdy));
    chk("busy", busy, eb);
    served = 1'b0; s_rd = '0; s_d = '0;
    if (frc || (!wb_valid && ne)) begin
      e = q.pop_front();
      s_rd = e.rd; s_d = e.d; served = 1'b1; losses = 0;
    end else if (wb_valid) begin
      s_rd = wb_rd; s_d = wb_data; served = 1'b1;
      losses = ne ? ((losses < STARVE_MAX) ? losses + 1 : STARVE_MAX) : 0;
    end else begin
      losses = 0;
    end
    wb_taken = wb_valid && !frc;
    lu_taken = lu_valid && rdy;
    if (lu_taken) begin
      e.rd = lu_rd; e.d = lu_data;
      q.push_back(e);
    end
    exp_rw = served && (s_rd != 0);
    if (served) begin exp_rd = s_rd; exp_wd = s_d; end
    @(posedge clk); #1;
  endtask

  task automatic next_inputs(input int pw, input int pl);
    if (!wb_valid || wb_taken) begin
      wb_valid = ($urandom_range(99) < pw);
      wb_rd    = 5'($urandom_range(31));
      wb_data  = $urandom;
    end
    if (!lu_valid || lu_taken) begin
      lu_valid = ($urandom_range(99) < pl);
      lu_rd    = 5'($urandom_range(31));
      lu_data  = $urandom;
    end
  endtask

  task automatic idle(input int n);
    wb_valid = 1'b0; lu_valid = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int n;
    model_clear();
    #3;
    chk("rst regwrite", 32'(regwrite), 32'd0);
    chk("rst rd", 32'(rd), 32'd0);
    chk("rst writedata", writedata, 32'd0);
    chk("rst lu_ready", 32'(lu_ready), 32'd1);
    chk("rst wb_stall", 32'(wb_stall), 32'd0);
    chk("rst busy", busy, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // WB only, including an x0 write that must be dropped
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234; cyc();
    wb_rd = 5'd0; wb_data = 32'hFFFF; cyc();
    idle(3);

    // LU into an idle writeback slot
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'hA5A5A5A5; cyc();
    idle(4);

    // Starvation with continuous writeback traffic
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'd0;
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'hDEAD;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (lu_taken) lu_valid = 1'b0;
      if (wb_taken) wb_data = wb_data + 1;
    end
    idle(3);

    // FIFO full: three LU results against saturated writeback
    n = 0;
    wb_valid = 1'b1; wb_rd = 5'd20; wb_data = 32'h100;
    lu_valid = 1'b1; lu_rd = 5'd11; lu_data = 32'd100;
    for (int i = 0; i < 25; i++) begin
      cyc();
      if (lu_taken) begin
        n++;
        if (n < 3) begin lu_rd = 5'(11 + n); lu_data = 32'(100 + n); end
        else lu_valid = 1'b0;
      end
      if (wb_taken) wb_data = wb_data + 1;
    end
    idle(3);

    // Duplicate destination while both are buffered behind writeback
    wb_valid = 1'b1; wb_rd = 5'd21; wb_data = 32'h200;
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'd1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (lu_taken) begin
        if (lu_data == 32'd1) lu_data = 32'd2; else lu_valid = 1'b0;
      end
      if (wb_taken) wb_data = wb_data + 1;
    end
    idle(4);

    // Mid-burst reset with two buffered entries
    wb_valid = 1'b1; wb_rd = 5'd22; wb_data = 32'h300;
    lu_valid = 1'b1; lu_rd = 5'd14; lu_data = 32'h55;
    n = 0;
    for (int i = 0; i < 8 && n < 2; i++) begin
      cyc();
      if (lu_taken) begin n++; lu_rd = 5'd15; lu_data = 32'h66; end
      if (wb_taken) wb_data = wb_data + 1;
    end
    lu_valid = 1'b0;
    chk("two buffered", 32'(q.size()), 32'd2);
    #2;
    rst_n = 1'b0; wb_valid = 1'b0;
    #1;
    chk("mid rst regwrite", 32'(regwrite), 32'd0);
    chk("mid rst lu_ready", 32'(lu_ready), 32'd1);
    chk("mid rst busy", busy, 32'd0);
    chk("mid rst wb_stall", 32'(wb_stall), 32'd0);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(5);

    // Random traffic, with phases of varying pressure
    for (int i = 0; i < 3000; i++) begin
      next_inputs((i < 1500) ? 60 : 95, (i < 1500) ? 40 : 70);
      cyc();
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
